// File: rtl/mem_arb_pkg.sv
// Shared types and the debug-vs-pipeline priority rule for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PIPE = 1'b0,
    DBG  = 1'b1
  } arb_owner_t;

  // Debug wins when the pipeline is quiet or has used up its consecutive-grant budget.
  function automatic logic dbg_win(input logic d_valid, input logic p_req, input logic at_max);
    return d_valid & (~p_req | at_max);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive pipeline grants taken while the debug port waits.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int W = (MAX > 0) ? $clog2(MAX + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the data-memory port between the MEM stage and a debug/loader port.
// Fixed MEM_LAT-cycle access plus one DONE cycle; pipeline stalls until its DONE.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [DATA_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_stall,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_read,
  output logic              m_write,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t        state_q;
  arb_owner_t        owner_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, p_rdata_q, d_rdata_q;
  logic [LAT_W-1:0]  lat_cnt_q;

  logic idle, at_max, grant_dbg, starve_inc;

  assign idle       = (state_q == IDLE);
  assign grant_dbg  = idle & dbg_win(d_valid, p_req, at_max);
  assign starve_inc = idle & p_req & d_valid & ~grant_dbg;

  arb_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i    (clock),
    .rst_ni   (reset),
    .inc_i    (starve_inc),
    .clr_i    (grant_dbg),
    .at_max_o (at_max)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= PIPE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt_q <= '0;
      p_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_dbg) begin
            we_q      <= d_we;
            addr_q    <= d_addr;
            wdata_q   <= d_wdata;
            owner_q   <= DBG;
            lat_cnt_q <= LAT_W'(MEM_LAT - 1);
            state_q   <= ACCESS;
          end else if (p_req) begin
            we_q      <= p_we;
            addr_q    <= p_addr;
            wdata_q   <= p_wdata;
            owner_q   <= PIPE;
            lat_cnt_q <= LAT_W'(MEM_LAT - 1);
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (lat_cnt_q == '0) begin
            state_q <= DONE;
            // Read data lands on the final strobe edge; a flushed pipeline read still updates.
            if (!we_q) begin
              if (owner_q == PIPE) p_rdata_q <= m_rdata;
              else                 d_rdata_q <= m_rdata;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q - 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;
  assign m_read   = (state_q == ACCESS) & ~we_q;
  assign m_write  = (state_q == ACCESS) &  we_q;
  assign busy     = ~idle;
  assign d_rvalid = (state_q == DONE) & (owner_q == DBG);
  assign d_ready  = idle & (~p_req | at_max);
  assign p_stall  = p_req & ~((state_q == DONE) & (owner_q == PIPE));
  assign p_rdata  = p_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single data-memory port between the pipeline MEM stage and a debug/loader requester. Sits between the EX_MEM register outputs and `data_memory`. Runs a fixed-latency access sequence and stalls the pipeline while a pipeline access is outstanding. Bounds pipeline priority with a starvation counter so the debug port is always served.

## Interface
Parameters:
- `DATA_W`, default 64: address and data width.
- `MEM_LAT`, default 2: cycles the memory needs per access. Must be ≥1.
- `STARVE_MAX`, default 4: maximum consecutive pipeline grants while the debug port waits. 0 gives the debug port strict priority.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `p_req` in 1: pipeline MEM-stage request, driven by mem_read|mem_write of EX_MEM.
- `p_we` in 1: pipeline write (1) or read (0).
- `p_addr` in DATA_W: pipeline address (ALU result).
- `p_wdata` in DATA_W: pipeline store data.
- `p_rdata` out DATA_W: pipeline load data, registered.
- `p_stall` out 1: hold PC, IF_ID, ID_EX and EX_MEM.
- `d_valid` in 1: debug request valid.
- `d_ready` out 1: debug request accepted this cycle.
- `d_we` in 1: debug write/read select.
- `d_addr` in DATA_W: debug address.
- `d_wdata` in DATA_W: debug write data.
- `d_rvalid` out 1: debug completion pulse.
- `d_rdata` out DATA_W: debug read data.
- `m_addr` out DATA_W: memory address.
- `m_wdata` out DATA_W: memory write data.
- `m_read` out 1: memory read strobe.
- `m_write` out 1: memory write strobe.
- `m_rdata` in DATA_W: memory read data.
- `busy` out 1: a transaction is in flight.

## Operation
States: IDLE, ACCESS, DONE.

**IDLE (arbitrate)**
- `dbg_win = d_valid & (~p_req | starve_cnt == STARVE_MAX)`.
- `d_ready = IDLE & (~p_req | starve_cnt == STARVE_MAX)`. The debug transfer happens when `d_valid & d_ready`.
- If the debug port wins: latch `d_we`, `d_addr` and `d_wdata` into `we_q`, `addr_q` and `wdata_q`. Set owner=DBG, clear `starve_cnt`, go to ACCESS.
- Otherwise, if `p_req`: latch the pipeline fields and set owner=PIPE. If `d_valid`, increment `starve_cnt`, saturating at STARVE_MAX. Go to ACCESS.
- With no request, stay in IDLE.

**ACCESS**
- Load `lat_cnt` with MEM_LAT-1 on entry. Decrement each cycle and leave when it reaches 0, so the state lasts exactly MEM_LAT cycles.
- Drive `m_addr=addr_q` and `m_wdata=wdata_q`.
- `m_read = ~we_q` and `m_write = we_q`, asserted on every ACCESS cycle.
- On the last ACCESS edge, when the access is a read, capture `m_rdata` into `p_rdata` (owner=PIPE) or `d_rdata` (owner=DBG).

**DONE**
- Lasts one cycle, then always returns to IDLE. There is no direct DONE→ACCESS transition.
- `d_rvalid = DONE & owner==DBG`. It pulses for reads and writes. `d_rdata` is unchanged after a debug write.

**Other outputs**
- `p_stall = p_req & ~(DONE & owner==PIPE)`.
- `busy = (state != IDLE)`.

**Boundary conditions**
- `p_req` dropping mid-ACCESS (flush): the access completes. The write is not aborted and `p_rdata` still updates.
- `d_valid` dropping without handshake: the debug port is not granted, and `starve_cnt` stops incrementing.
- Reset asserted mid-operation: the state goes to IDLE immediately. `m_read` and `m_write` drop in the same cycle, and every counter and register clears.

## Timing
- Reset values:
  - state=IDLE.
  - `p_rdata`, `d_rdata`, `addr_q`, `wdata_q` = 0.
  - `starve_cnt`, `lat_cnt` = 0.
  - `m_read`, `m_write`, `d_rvalid`, `busy` = 0.
  - `m_addr` and `m_wdata` = 0.
  - `p_stall` and `d_ready` follow the IDLE equations.
- Pipeline access with `p_req` first seen in IDLE at cycle 0:
  - ACCESS on cycles 1..MEM_LAT, DONE on cycle MEM_LAT+1.
  - `p_stall` = 1 on cycles 0..MEM_LAT and 0 on cycle MEM_LAT+1.
  - `p_rdata` is valid from cycle MEM_LAT+1 and holds until the next pipeline read completes.
- Debug access handshaken at cycle 0: `d_rvalid` at cycle MEM_LAT+1.
- Throughput: one transaction per MEM_LAT+2 cycles.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` enum {IDLE, ACCESS, DONE}.
  - `arb_owner_t` enum {PIPE, DBG}.
  - the `dbg_win` priority function.
- Sub-module `arb_starve_counter`: a saturating counter with inc, clr and `at_max` outputs. Width is `$clog2(STARVE_MAX+1)`, minimum 1.
- All memory outputs are decoded from registered state.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=2.
- **Reset:** release reset, no requests. All outputs 0, `d_ready`=1, `busy`=0.
- **Pipeline read:** `p_req`=1, `p_we`=0, `p_addr`=0x40, memory returns 0xDEAD. `p_stall` is 1 for 3 cycles then 0. `p_rdata`=0xDEAD on cycle 3. `m_read` is high on cycles 1–2 only.
- **Debug write:** `d_valid`, `d_we`=1, `d_addr`=0x8, `d_wdata`=0x55, no `p_req`. `d_ready`=1 on cycle 0. `m_write` on cycles 1–2 with `m_addr`=0x8. `d_rvalid` pulses on cycle 3.
- **Starvation:** `p_req` and `d_valid` held continuously. Grants go PIPE, PIPE, DBG, PIPE, PIPE, DBG. `d_ready` is high only in the IDLE cycle preceding each DBG grant.
- **Reset mid-ACCESS:** assert reset on cycle 1 of a write. `m_write` drops immediately and there is no DONE. After release, a new `p_req` starts cleanly from IDLE.
- **Flush mid-access:** `p_req` drops on cycle 1 of a pipeline write. `m_write` still lasts 2 cycles, DONE occurs, and `p_stall` stays 0.
